// File: rtl/eth_pcs_tx_am_dist.sv
// PCS TX alignment-marker distributor: stripes N_LANES blocks per beat onto PCS lanes and
// periodically replaces a beat with per-lane alignment markers carrying running BIP parity.
module eth_pcs_tx_am_dist #(
  parameter int unsigned               N_LANES      = 4,
  parameter int unsigned               AM_PERIOD    = 16384,
  parameter int unsigned               W_SYNC       = 2,
  parameter int unsigned               W_PLD        = 64,
  parameter logic [W_SYNC-1:0]         AM_SYNC      = 2'b01,
  parameter logic [N_LANES-1:0][23:0]  AM_LANE_CODE = {24'h3D79A2, 24'h9B65C5,
                                                       24'hE6C4F0, 24'h477690}
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [N_LANES-1:0][W_SYNC-1:0]   i_sync,
  input  logic [N_LANES-1:0][W_PLD-1:0]    i_pld,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [N_LANES-1:0][W_SYNC-1:0]   o_sync,
  output logic [N_LANES-1:0][W_PLD-1:0]    o_pld,
  output logic                             o_am
);

  localparam int unsigned CNT_W = $clog2(AM_PERIOD);

  typedef enum logic {StAm, StData} state_e;

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 valid_q, valid_d;
  logic                                 am_q, am_d;
  logic [N_LANES-1:0][W_SYNC-1:0]       sync_q, sync_d;
  logic [N_LANES-1:0][W_PLD-1:0]        pld_q, pld_d;
  logic [N_LANES-1:0][7:0]              acc_q, acc_d;
  logic [N_LANES-1:0][W_PLD-1:0]        am_pld;
  logic                                 ld;
  logic                                 ready;

  // Bit i of the BIP is the XOR of every bit j of {pld, sync} with j mod 8 == i.
  function automatic logic [7:0] bip_of(input logic [W_SYNC-1:0] s,
                                        input logic [W_PLD-1:0]  p);
    logic [W_SYNC+W_PLD-1:0] v;
    logic [7:0]              r;
    v = {p, s};
    r = '0;
    for (int j = 0; j < W_SYNC + W_PLD; j++) begin
      r[j[2:0]] = r[j[2:0]] ^ v[j];
    end
    return r;
  endfunction

  // Marker bytes from LSB: M0 M1 M2 BIP3 ~M0 ~M1 ~M2 ~BIP3.
  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      am_pld[l] = {~acc_q[l], ~AM_LANE_CODE[l], acc_q[l], AM_LANE_CODE[l]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    am_d    = am_q;
    sync_d  = sync_q;
    pld_d   = pld_q;
    acc_d   = acc_q;
    ld      = !valid_q || i_ready;
    ready   = (state_q == StData) && ld;

    unique case (state_q)
      StAm: begin
        if (ld) begin
          valid_d = 1'b1;
          am_d    = 1'b1;
          cnt_d   = '0;
          pld_d   = am_pld;
          for (int l = 0; l < N_LANES; l++) begin
            sync_d[l] = AM_SYNC;
            acc_d[l]  = bip_of(AM_SYNC, am_pld[l]);
          end
          state_d = StData;
        end
      end
      StData: begin
        if (i_valid && ready) begin
          valid_d = 1'b1;
          am_d    = 1'b0;
          sync_d  = i_sync;
          pld_d   = i_pld;
          cnt_d   = cnt_q + CNT_W'(1);
          for (int l = 0; l < N_LANES; l++) begin
            acc_d[l] = acc_q[l] ^ bip_of(i_sync[l], i_pld[l]);
          end
          if (cnt_q == CNT_W'(AM_PERIOD - 2)) begin
            state_d = StAm;
          end
        end else if (ld) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = StAm;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StAm;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      am_q    <= 1'b0;
      sync_q  <= '0;
      pld_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      am_q    <= am_d;
      sync_q  <= sync_d;
      pld_q   <= pld_d;
      acc_q   <= acc_d;
    end
  end

  assign o_ready = ready;
  assign o_valid = valid_q;
  assign o_am    = am_q;
  assign o_sync  = sync_q;
  assign o_pld   = pld_q;

endmodule

// File: tb/tb_eth_pcs_tx_am_dist.sv
// Bench for eth_pcs_tx_am_dist: scoreboarded 4-lane instance plus a 2-lane custom-code instance.
module tb_eth_pcs_tx_am_dist;

  localparam int NL  = 4;
  localparam int PER = 4;
  localparam logic [NL-1:0][23:0] CODES  = {24'h3D79A2, 24'h9B65C5, 24'hE6C4F0, 24'h477690};
  localparam logic [1:0][23:0]    CODES2 = {24'h0FE17B, 24'hC35A12};

  typedef logic [NL-1:0][1:0]  sync_t;
  typedef logic [NL-1:0][63:0] pld_t;
  typedef struct packed {
    logic  am;
    sync_t sync;
    pld_t  pld;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  i_reset, i_valid, i_ready, o_ready, o_valid, o_am;
  sync_t i_sync, o_sync;
  pld_t  i_pld, o_pld;

  logic             rst2, v2, r2, o_ready2, o_valid2, o_am2;
  logic [1:0][1:0]  s2, os2;
  logic [1:0][63:0] p2, op2;

  eth_pcs_tx_am_dist #(.N_LANES(NL), .AM_PERIOD(PER)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_sync(i_sync), .i_pld(i_pld), .o_valid(o_valid), .i_ready(i_ready),
    .o_sync(o_sync), .o_pld(o_pld), .o_am(o_am)
  );

  eth_pcs_tx_am_dist #(.N_LANES(2), .AM_PERIOD(PER), .AM_LANE_CODE(CODES2)) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_valid(v2), .o_ready(o_ready2),
    .i_sync(s2), .i_pld(p2), .o_valid(o_valid2), .i_ready(r2),
    .o_sync(os2), .o_pld(op2), .o_am(o_am2)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  logic  m_valid, m_pend, zero_mode;
  int    m_cnt, am_idx;
  logic [NL-1:0][7:0] m_acc;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Fold the 66-bit block into bytes; XOR of the bytes is the 8-way interleaved parity.
  function automatic logic [7:0] par66(input logic [1:0] s, input logic [63:0] p);
    logic [71:0] v;
    logic [7:0]  r;
    v = {6'b0, p, s};
    r = '0;
    for (int k = 0; k < 9; k++) r ^= v[8*k +: 8];
    return r;
  endfunction

  function automatic logic [63:0] am_blk(input logic [23:0] code, input logic [7:0] bip);
    return {~bip, ~code, bip, code};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pend  = 1'b1;
    m_cnt   = 0;
    m_acc   = '0;
    am_idx  = 0;
    sb.delete();
  endtask

  task automatic rnd(output sync_t s, output pld_t p);
    for (int l = 0; l < NL; l++) begin
      s[l] = 2'($urandom_range(1, 2));
      p[l] = {$urandom(), $urandom()};
    end
  endtask

  // One clock: drive, check/model at negedge, advance to just after the next posedge.
  task automatic cyc(input logic v, input logic r, input logic rst, input sync_t s,
                     input pld_t p);
    logic  ld;
    beat_t f, b;
    i_valid = v; i_ready = r; i_reset = rst; i_sync = s; i_pld = p;
    @(negedge clk);
    ld = !m_valid || r;
    chk("o_valid", 256'(o_valid), 256'(m_valid));
    chk("o_ready", 256'(o_ready), 256'(ld && !m_pend));
    if (m_valid) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_empty: got size %0d want >0", sb.size());
      end
      if (sb.size() > 0) begin
        f = sb[0];
        chk("o_am", 256'(o_am), 256'(f.am));
        chk("o_sync", 256'(o_sync), 256'(f.sync));
        chk("o_pld", 256'(o_pld), 256'(f.pld));
        if (r) begin
          if (f.am) begin
            if (am_idx == 0) begin
              chk("am_first_l0", 256'(o_pld[0]), 256'(64'hFFB8896F00477690));
              chk("am_first_l3_code", 256'(o_pld[3][23:0]), 256'(24'h3D79A2));
            end
            if (am_idx == 1 && zero_mode) begin
              for (int l = 0; l < NL; l++) begin
                chk("am2_bip3", 256'(o_pld[l][31:24]), 256'(8'h03));
                chk("am2_bip7", 256'(o_pld[l][63:56]), 256'(8'hFC));
              end
            end
            am_idx++;
          end
          void'(sb.pop_front());
        end
      end
    end
    if (ld && m_pend) begin
      b.am = 1'b1;
      for (int l = 0; l < NL; l++) begin
        b.pld[l]  = am_blk(CODES[l], m_acc[l]);
        b.sync[l] = 2'b01;
        m_acc[l]  = par66(2'b01, b.pld[l]);
      end
      sb.push_back(b);
      m_cnt = 0; m_pend = 1'b0; m_valid = 1'b1;
    end else if (ld && v) begin
      b.am = 1'b0; b.sync = s; b.pld = p;
      for (int l = 0; l < NL; l++) m_acc[l] ^= par66(s[l], p[l]);
      sb.push_back(b);
      m_cnt++;
      if (m_cnt == PER - 1) m_pend = 1'b1;
      m_valid = 1'b1;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  sync_t zs, s10, rs;
  pld_t  zp, rp;
  logic  gap_pat [9] = '{1, 0, 0, 1, 0, 1, 1, 0, 1};

  initial begin
    zs = '0; zp = '0;
    for (int l = 0; l < NL; l++) s10[l] = 2'b10;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sync = zs; i_pld = zp;
    rst2 = 1'b1; v2 = 1'b0; r2 = 1'b1; s2 = '0; p2 = '0;
    zero_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", 256'(o_valid), 256'(0));
    chk("rst_am", 256'(o_am), 256'(0));
    chk("rst_sync", 256'(o_sync), 256'(0));
    chk("rst_pld", 256'(o_pld), 256'(0));
    cyc(1'b0, 1'b1, 1'b1, zs, zp);

    // Full throughput with all-zero payloads and sync 10 for the BIP check.
    zero_mode = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, s10, zp);
    zero_mode = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rnd(rs, rp);
      cyc(1'b1, 1'b1, 1'b0, rs, rp);
    end

    // Backpressure mid-period.
    for (int i = 0; i < 5; i++) begin
      rnd(rs, rp);
      cyc(1'b1, 1'b0, 1'b0, rs, rp);
    end
    for (int i = 0; i < 6; i++) begin
      rnd(rs, rp);
      cyc(1'b1, 1'b1, 1'b0, rs, rp);
    end

    // Input gaps.
    foreach (gap_pat[i]) begin
      rnd(rs, rp);
      cyc(gap_pat[i], 1'b1, 1'b0, rs, rp);
    end

    // Random valid/ready mix.
    for (int i = 0; i < 40; i++) begin
      rnd(rs, rp);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, rs, rp);
    end

    // Reset after D1 accepted; the first beat afterwards must be a fresh AM.
    cyc(1'b1, 1'b1, 1'b1, zs, zp);
    for (int i = 0; i < 3; i++) begin
      rnd(rs, rp);
      cyc(1'b1, 1'b1, 1'b0, rs, rp);
    end
    rnd(rs, rp);
    cyc(1'b1, 1'b1, 1'b1, rs, rp);
    for (int i = 0; i < 8; i++) begin
      rnd(rs, rp);
      cyc(1'b1, 1'b1, 1'b0, rs, rp);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, zs, zp);

    // Two-lane instance with custom marker codes.
    i_valid = 1'b0;
    v2 = 1'b1; r2 = 1'b1; rst2 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("d2_valid", 256'(o_valid2), 256'(1));
      chk("d2_am", 256'(o_am2), 256'((i % 4) == 0));
      if (i == 0) begin
        chk("d2_am_sync", 256'(os2), 256'(4'b0101));
        chk("d2_l0_am", 256'(op2[0]), 256'(64'hFF3CA5ED00C35A12));
        chk("d2_l1_am", 256'(op2[1]), 256'(64'hFFF01E84000FE17B));
      end
      @(posedge clk);
      #1;
      s2 = {2'b10, 2'b01};
      p2 = {{$urandom(), $urandom()}, {$urandom(), $urandom()}};
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_pcs_tx_am_dist.md
# eth_pcs_tx_am_dist

Parametrised multi-lane successor stage for the PCS TX path (40G/100G-style). Accepts one beat of N_LANES scrambled 66-bit blocks per transfer, block k going to PCS lane k. Periodically inserts a per-lane alignment marker (AM) carrying running BIP parity, and presents the lane-striped result to the lane gearboxes through a registered valid/ready interface.

## Interface
- N_LANES, 4, number of PCS lanes (>=1)
- AM_PERIOD, 16384, beats per marker period including the AM beat (>=2)
- W_SYNC, 2, sync header width
- W_PLD, 64, block payload width
- AM_SYNC, 2'b01, sync header of AM blocks (control header, LSB transmitted first)
- AM_LANE_CODE, [N_LANES][24], per-lane {M2,M1,M0}. Default lane0..3 M0/M1/M2 = 90/76/47, F0/C4/E6, C5/65/9B, A2/79/3D (hex)

Ports:
- i_clk  in  1  single clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid & o_ready
- i_sync  in  [N_LANES][W_SYNC]  per-lane sync headers
- i_pld  in  [N_LANES][W_PLD]  per-lane scrambled payloads
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready; transfer on o_valid & i_ready
- o_sync  out  [N_LANES][W_SYNC]  per-lane output sync
- o_pld  out  [N_LANES][W_PLD]  per-lane output payload
- o_am  out  1  current output beat is an AM beat

## Operation
- Output register load enable: ld = !o_valid | i_ready. On ld, register takes the new beat (if any); o_valid <= beat produced.
- FSM, 2 states:
  - S_AM: o_ready=0. If ld, load AM on all lanes, set o_am=1, cnt<=0, go S_DATA.
  - S_DATA: o_ready=ld. On i_valid & o_ready, load input beat, o_am=0, cnt<=cnt+1. If the accepted beat has cnt==AM_PERIOD-2, go S_AM. If ld & !i_valid, o_valid<=0.
- cnt: $clog2(AM_PERIOD) bits, counts accepted data beats only. Idle input cycles do not advance it.
- AM payload for lane l, byte 0 in pld[7:0]: M0, M1, M2, BIP3, ~M0, ~M1, ~M2, ~BIP3. Sync = AM_SYNC.
- BIP per lane: 8-bit acc[l]. Parity vector v = {pld[63:0], sync[1:0]} (66 bits); bit i = XOR of v[j] for all j with j mod 8 == i.
  - Data beat loaded: acc[l] ^= parity(block).
  - AM beat loaded: BIP3 = acc[l]; acc[l] <= parity(AM block just formed).
- AM blocks are never scrambled. Data blocks pass bit-exact.
- Reset: o_valid=0, o_am=0, o_sync/o_pld=0, state S_AM, cnt=0, all acc=0. The first output beat after reset is an AM with BIP3=0x00.
- Reset mid-operation discards the held beat and restarts the period. No partial-period marker is emitted.

## Timing
- Latency: 1 cycle from accepted input, or from AM generation, to o_valid.
- o_ready depends combinationally on i_ready and o_valid. No combinational path from i_valid to any output.
- Full throughput: with i_ready=1 and i_valid=1, the pattern is AM then AM_PERIOD-1 data beats, repeating. o_ready is low exactly during the AM-load cycle.
- While o_valid & !i_ready, o_sync/o_pld/o_am hold stable and no input is accepted.
- Simultaneous i_reset and a transfer: reset wins; the beat is dropped.

## Test plan
- AM_PERIOD=4, N_LANES=4, i_valid=i_ready=1 after reset -> outputs AM, D0, D1, D2, AM, D3 …; first lane0 o_pld=0xFFB8896F00477690, o_sync=2'b01; lane3 M0..M2=A2/79/3D.
- BIP: data beats all sync=2'b10, pld=0 -> second AM lane0 BIP3=0x03 (AM parity 0x01 ^ 3×0x02), BIP7=0xFC, identical on all lanes.
- Backpressure: hold i_ready=0 for 5 cycles mid-period -> o_valid=1, outputs unchanged, o_ready=0. Resume -> no beat lost or duplicated; AM still follows exactly 3 data beats.
- Input gaps: i_valid toggling 1,0,0,1,0,1 -> cnt advances only on accepted beats; AM inserted after the 3rd accepted data beat.
- Reset after D1 accepted -> next cycle o_valid=0; first beat after release is AM with BIP3=0x00, BIP7=0xFF.
- N_LANES=2 with custom AM_LANE_CODE -> lane1 marker bytes match the codes plus their complements; the period pattern matches the first scenario.
